// File: rtl/sap1_ctrl_seq.sv
// sap1_ctrl_seq: SAP-1 controller-sequencer.
// A one-hot six-state ring (T1..T6) walks fetch and execute. The current
// T-state plus the IR opcode decode into the machine's control word.
// Supports free-run and single-step; HLT freezes the ring until clr.
//
// Ports
//   clk                       system clock, rising edge
//   clr                       synchronous reset, active-high
//   auto                      1 = free-run, 0 = single-step
//   step                      single-step request level (synchronous to clk)
//   opcode[OP_W-1:0]          IR opcode field, valid from T4 onward
//   t_state[5:0]              one-hot ring state, bit0 = T1 (all zero when halted)
//   halt                      machine halted
//   cp, lm, li, la, lb, lo    strobes: PC incr, MAR/IR/A/B/OUT load (advance-qualified)
//   ep, ce, ei, ea, eu        bus enables: PC, RAM, IR, A, ALU
//   su                        ALU subtract select
module sap1_ctrl_seq #(
    parameter int unsigned     OP_W   = 4,
    parameter logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000),
    parameter logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001),
    parameter logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010),
    parameter logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110),
    parameter logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            auto,
    input  logic            step,
    input  logic [OP_W-1:0] opcode,
    output logic [5:0]      t_state,
    output logic            halt,
    output logic            cp,
    output logic            lm,
    output logic            li,
    output logic            la,
    output logic            lb,
    output logic            lo,
    output logic            ep,
    output logic            ce,
    output logic            ei,
    output logic            ea,
    output logic            eu,
    output logic            su
);

    // Ring encoding doubles as the T_STATE output; halted is the all-zero code.
    typedef enum logic [5:0] {
        S_T1  = 6'b000001,
        S_T2  = 6'b000010,
        S_T3  = 6'b000100,
        S_T4  = 6'b001000,
        S_T5  = 6'b010000,
        S_T6  = 6'b100000,
        S_HLT = 6'b000000
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   step_q;
    logic   adv;
    logic   cp_r, lm_r, li_r, la_r, lb_r, lo_r;
    logic   mem_op;

    // State register and step-edge history. step_q resets high so a step
    // level held through reset is not mistaken for a new request.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= S_T1;
            step_q <= 1'b1;
        end else begin
            state  <= state_nxt;
            step_q <= step;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_nxt = state;
        adv       = auto | (step & ~step_q);
        mem_op    = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);
        cp_r      = 1'b0;
        lm_r      = 1'b0;
        li_r      = 1'b0;
        la_r      = 1'b0;
        lb_r      = 1'b0;
        lo_r      = 1'b0;
        ep        = 1'b0;
        ce        = 1'b0;
        ei        = 1'b0;
        ea        = 1'b0;
        eu        = 1'b0;
        su        = 1'b0;

        case (state)
            S_T1: begin
                ep   = 1'b1;
                lm_r = 1'b1;
                if (adv) state_nxt = S_T2;
            end
            S_T2: begin
                cp_r = 1'b1;
                if (adv) state_nxt = S_T3;
            end
            S_T3: begin
                ce   = 1'b1;
                li_r = 1'b1;
                if (adv) state_nxt = S_T4;
            end
            S_T4: begin
                if (mem_op) begin
                    ei   = 1'b1;
                    lm_r = 1'b1;
                end else if (opcode == OP_OUT) begin
                    ea   = 1'b1;
                    lo_r = 1'b1;
                end
                if (adv) state_nxt = (opcode == OP_HLT) ? S_HLT : S_T5;
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ce   = 1'b1;
                    la_r = 1'b1;
                end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    ce   = 1'b1;
                    lb_r = 1'b1;
                end
                if (adv) state_nxt = S_T6;
            end
            S_T6: begin
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    eu   = 1'b1;
                    la_r = 1'b1;
                    su   = (opcode == OP_SUB);
                end
                if (adv) state_nxt = S_T1;
            end
            S_HLT: state_nxt = S_HLT;
            default: state_nxt = S_T1;
        endcase

        // Strobes fire only on the edge that leaves the T-state.
        cp = cp_r & adv;
        lm = lm_r & adv;
        li = li_r & adv;
        la = la_r & adv;
        lb = lb_r & adv;
        lo = lo_r & adv;
    end

    assign t_state = state;
    assign halt    = (state == S_HLT);

    // Only one source may drive the bus at a time.
    a_one_bus_driver: assert property (@(posedge clk) disable iff (clr)
        $onehot0({ep, ce, ei, ea, eu}));

endmodule

// File: tb/tb_sap1_ctrl_seq.sv
// tb_sap1_ctrl_seq: table-driven vectors, hand sequences for stepping, halt
// and mid-instruction clear, then random stimulus against a behavioural model.
module tb_sap1_ctrl_seq;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [3:0] OP_NOP = 4'b0101;

    // Control word order: {cp,lm,li,la,lb,lo,ep,ce,ei,ea,eu,su}
    localparam logic [11:0] C_CP = 12'h800;
    localparam logic [11:0] C_LM = 12'h400;
    localparam logic [11:0] C_LI = 12'h200;
    localparam logic [11:0] C_LA = 12'h100;
    localparam logic [11:0] C_LB = 12'h080;
    localparam logic [11:0] C_LO = 12'h040;
    localparam logic [11:0] C_EP = 12'h020;
    localparam logic [11:0] C_CE = 12'h010;
    localparam logic [11:0] C_EI = 12'h008;
    localparam logic [11:0] C_EA = 12'h004;
    localparam logic [11:0] C_EU = 12'h002;
    localparam logic [11:0] C_SU = 12'h001;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic       clk;
    logic       clr_i, auto_i, step_i;
    logic [3:0] op_i;
    logic [5:0] t_state;
    logic       halt;
    logic       cp, lm, li, la, lb, lo, ep, ce, ei, ea, eu, su;
    logic [11:0] ctrl;

    int n_chk;
    int n_err;

    // Reference model: T-state as an integer 1..6, 0 meaning halted.
    int m_t;
    bit m_sq;

    typedef struct {
        logic       clr;
        logic       auto_;
        logic       step;
        logic [3:0] op;
        logic [5:0] t;
        logic [11:0] c;
    } vec_t;

    vec_t tbl[$];

    sap1_ctrl_seq dut (
        .clk    (clk),
        .clr    (clr_i),
        .auto   (auto_i),
        .step   (step_i),
        .opcode (op_i),
        .t_state(t_state),
        .halt   (halt),
        .cp     (cp),
        .lm     (lm),
        .li     (li),
        .la     (la),
        .lb     (lb),
        .lo     (lo),
        .ep     (ep),
        .ce     (ce),
        .ei     (ei),
        .ea     (ea),
        .eu     (eu),
        .su     (su)
    );

    assign ctrl = {cp, lm, li, la, lb, lo, ep, ce, ei, ea, eu, su};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_adv();
        return auto_i | (step_i & ~m_sq);
    endfunction

    function automatic logic [5:0] ref_t();
        if (m_t == 0) return 6'b000000;
        return 6'(32'd1 << (m_t - 1));
    endfunction

    // Control word straight from the T-state/opcode table.
    function automatic logic [11:0] ref_ctrl();
        logic [11:0] s;
        logic [11:0] e;
        bit arith;
        s = '0;
        e = '0;
        arith = (op_i == OP_ADD) || (op_i == OP_SUB);
        case (m_t)
            1: begin e = C_EP; s = C_LM; end
            2: s = C_CP;
            3: begin e = C_CE; s = C_LI; end
            4: if (arith || op_i == OP_LDA) begin e = C_EI; s = C_LM; end
               else if (op_i == OP_OUT) begin e = C_EA; s = C_LO; end
            5: if (op_i == OP_LDA) begin e = C_CE; s = C_LA; end
               else if (arith) begin e = C_CE; s = C_LB; end
            6: if (arith) begin
                   e = C_EU | ((op_i == OP_SUB) ? C_SU : 12'h000);
                   s = C_LA;
               end
            default: ;
        endcase
        return (ref_adv() ? s : 12'h000) | e;
    endfunction

    task automatic apply(input logic c, input logic a, input logic s, input logic [3:0] o);
        clr_i  = c;
        auto_i = a;
        step_i = s;
        op_i   = o;
        #1;
    endtask

    task automatic chk(input string nm, input logic [5:0] et, input logic eh, input logic [11:0] ec);
        n_chk++;
        if (t_state !== et || halt !== eh || ctrl !== ec) begin
            n_err++;
            $display("FAIL %s: got t=%b halt=%b ctrl=%b, want t=%b halt=%b ctrl=%b",
                     nm, t_state, halt, ctrl, et, eh, ec);
        end
        n_chk++;
        if (!$onehot0({ep, ce, ei, ea, eu})) begin
            n_err++;
            $display("FAIL %s_bus: enables=%b, want at most one set", nm, {ep, ce, ei, ea, eu});
        end
    endtask

    // Clock edge, then advance the model with the inputs that were applied.
    task automatic tick();
        bit a;
        @(posedge clk);
        a = ref_adv();
        if (clr_i) begin
            m_t  = 1;
            m_sq = 1'b1;
        end else begin
            if (m_t != 0 && a) begin
                if (m_t == 4 && op_i == OP_HLT) m_t = 0;
                else m_t = (m_t % 6) + 1;
            end
            m_sq = step_i;
        end
        @(negedge clk);
    endtask

    task automatic add(input logic [3:0] o, input logic [5:0] t, input logic [11:0] c);
        vec_t v;
        v.clr = 1'b0; v.auto_ = 1'b1; v.step = 1'b0; v.op = o; v.t = t; v.c = c;
        tbl.push_back(v);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_t   = 1;
        m_sq  = 1'b1;

        // Free-running instruction rings, one per opcode class.
        add(OP_LDA, T1, C_EP | C_LM); add(OP_LDA, T2, C_CP); add(OP_LDA, T3, C_CE | C_LI);
        add(OP_LDA, T4, C_EI | C_LM); add(OP_LDA, T5, C_CE | C_LA); add(OP_LDA, T6, 12'h000);
        add(OP_SUB, T1, C_EP | C_LM); add(OP_SUB, T2, C_CP); add(OP_SUB, T3, C_CE | C_LI);
        add(OP_SUB, T4, C_EI | C_LM); add(OP_SUB, T5, C_CE | C_LB); add(OP_SUB, T6, C_EU | C_SU | C_LA);
        add(OP_ADD, T1, C_EP | C_LM); add(OP_ADD, T2, C_CP); add(OP_ADD, T3, C_CE | C_LI);
        add(OP_ADD, T4, C_EI | C_LM); add(OP_ADD, T5, C_CE | C_LB); add(OP_ADD, T6, C_EU | C_LA);
        add(OP_OUT, T1, C_EP | C_LM); add(OP_OUT, T2, C_CP); add(OP_OUT, T3, C_CE | C_LI);
        add(OP_OUT, T4, C_EA | C_LO); add(OP_OUT, T5, 12'h000); add(OP_OUT, T6, 12'h000);
        add(OP_NOP, T1, C_EP | C_LM); add(OP_NOP, T2, C_CP); add(OP_NOP, T3, C_CE | C_LI);
        add(OP_NOP, T4, 12'h000); add(OP_NOP, T5, 12'h000); add(OP_NOP, T6, 12'h000);
        add(OP_LDA, T1, C_EP | C_LM);

        apply(1'b1, 1'b1, 1'b0, OP_LDA);
        @(negedge clk);
        tick();
        foreach (tbl[i]) begin
            apply(tbl[i].clr, tbl[i].auto_, tbl[i].step, tbl[i].op);
            chk($sformatf("vec%0d", i), tbl[i].t, 1'b0, tbl[i].c);
            tick();
        end

        // Single-step: one advance per rising STEP, enables hold while stalled.
        apply(1'b1, 1'b0, 1'b0, OP_LDA); tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, OP_LDA); chk("step_idle_t1", T1, 1'b0, C_EP); tick();
        end
        apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_pulse_t1", T1, 1'b0, C_EP | C_LM); tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, OP_LDA); chk("step_idle_t2", T2, 1'b0, 12'h000); tick();
        end
        apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_cp", T2, 1'b0, C_CP); tick();
        apply(1'b0, 1'b0, 1'b0, OP_LDA); chk("step_cp_once", T3, 1'b0, C_CE); tick();
        apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_hold_first", T3, 1'b0, C_CE | C_LI); tick();
        for (int i = 1; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_hold", T4, 1'b0, C_EI); tick();
        end
        apply(1'b0, 1'b0, 1'b0, OP_LDA); chk("step_release", T4, 1'b0, C_EI); tick();

        // Step level held through reset must not advance.
        apply(1'b1, 1'b0, 1'b1, OP_LDA); tick();
        apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_across_clr", T1, 1'b0, C_EP); tick();
        apply(1'b0, 1'b0, 1'b1, OP_LDA); chk("step_across_clr2", T1, 1'b0, C_EP); tick();

        // Halt freezes everything until clr.
        apply(1'b1, 1'b1, 1'b0, OP_HLT); tick();
        apply(1'b0, 1'b1, 1'b0, OP_HLT); chk("hlt_t1", T1, 1'b0, C_EP | C_LM); tick();
        apply(1'b0, 1'b1, 1'b0, OP_HLT); chk("hlt_t2", T2, 1'b0, C_CP); tick();
        apply(1'b0, 1'b1, 1'b0, OP_HLT); chk("hlt_t3", T3, 1'b0, C_CE | C_LI); tick();
        apply(1'b0, 1'b1, 1'b0, OP_HLT); chk("hlt_t4", T4, 1'b0, 12'h000); tick();
        for (int i = 0; i < 20; i++) begin
            apply(1'b0, 1'(i % 3 == 0), 1'(i % 2), (i % 4 == 0) ? OP_LDA : OP_HLT);
            chk("halted", 6'b000000, 1'b1, 12'h000);
            tick();
        end
        apply(1'b1, 1'b1, 1'b0, OP_HLT); tick();
        apply(1'b0, 1'b0, 1'b0, OP_LDA); chk("hlt_clr", T1, 1'b0, C_EP); tick();

        // Clear in T5 of ADD abandons the instruction.
        apply(1'b1, 1'b1, 1'b0, OP_ADD); tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, OP_ADD); tick();
        end
        apply(1'b1, 1'b1, 1'b0, OP_ADD); chk("clr_in_t5", T5, 1'b0, C_CE | C_LB); tick();
        apply(1'b0, 1'b1, 1'b0, OP_ADD); chk("after_clr_t1", T1, 1'b0, C_EP | C_LM); tick();
        apply(1'b0, 1'b1, 1'b0, OP_ADD); chk("after_clr_t2", T2, 1'b0, C_CP); tick();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] o;
            case ($urandom_range(0, 5))
                0: o = OP_LDA;
                1: o = OP_ADD;
                2: o = OP_SUB;
                3: o = OP_OUT;
                4: o = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_NOP;
                default: o = 4'($urandom);
            endcase
            apply(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), o);
            chk($sformatf("rand%0d", i), ref_t(), 1'(m_t == 0), ref_ctrl());
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
